// File: rtl/bcd_to_half_fsm_pkg.sv
// Shared widths, state codes and BCD helpers for the BCD to binary16 converter.
package bcd_to_half_fsm_pkg;

    localparam int HALF_W       = 16;
    localparam int MANT_W       = 10;
    localparam int EXP_W        = 5;
    localparam int ACC_W        = 14;
    localparam int DIGITS       = 4;
    localparam int BCD_W        = 4 * DIGITS;
    localparam int DEF_EXP_BIAS = 15;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t CHECK = 3'd1;
    localparam state_t ACC   = 3'd2;
    localparam state_t NORM  = 3'd3;
    localparam state_t ROUND = 3'd4;
    localparam state_t DONE  = 3'd5;

    // True when every nibble of the operand is a legal decimal digit.
    function automatic logic bcd_valid(input logic [BCD_W-1:0] operand);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            ok = ok & (operand[4*i +: 4] <= 4'd9);
        end
        return ok;
    endfunction

    // acc*10 + digit built from two shifts; the caller guarantees no overflow.
    function automatic logic [ACC_W-1:0] times_ten_plus(input logic [ACC_W-1:0] acc,
                                                        input logic [3:0]       digit);
        return {acc[ACC_W-4:0], 3'b000} + {acc[ACC_W-2:0], 1'b0} + {{(ACC_W-4){1'b0}}, digit};
    endfunction

endpackage

// File: rtl/half_pack_round.sv
// Packs a left-normalised 14-bit integer and its biased exponent into binary16,
// applying round-to-nearest-even and mantissa carry into the exponent.
module half_pack_round
    import bcd_to_half_fsm_pkg::*;
#(
    parameter logic ROUND_EVEN = 1'b1
) (
    input  logic [ACC_W-1:0]  norm_val,
    input  logic [EXP_W-1:0]  exp_val,
    output logic [HALF_W-1:0] half_word
);

    logic [MANT_W-1:0] mant_s;
    logic              guard_s;
    logic              sticky_s;
    logic              inc_s;
    logic [MANT_W:0]   mant_sum_s;

    // Bit 13 is the hidden one; the ten bits below it form the mantissa.
    always_comb begin
        mant_s     = norm_val[ACC_W-2 -: MANT_W];
        guard_s    = norm_val[ACC_W-2-MANT_W];
        sticky_s   = |norm_val[ACC_W-3-MANT_W:0];
        inc_s      = ROUND_EVEN ? (guard_s & (sticky_s | mant_s[0])) : 1'b0;
        mant_sum_s = {1'b0, mant_s} + {{MANT_W{1'b0}}, inc_s};
        if (norm_val == '0) begin
            half_word = '0;
        end else if (mant_sum_s[MANT_W]) begin
            half_word = {1'b0, exp_val + 5'd1, {MANT_W{1'b0}}};
        end else begin
            half_word = {1'b0, exp_val, mant_sum_s[MANT_W-1:0]};
        end
    end

endmodule

// File: rtl/bcd_to_half_fsm.sv
// Converts a latched 4-digit BCD operand into its binary16 encoding with a
// start/done pulse handshake and a one-cycle invalid-digit pulse.
module bcd_to_half_fsm
    import bcd_to_half_fsm_pkg::*;
#(
    parameter int   EXP_BIAS   = DEF_EXP_BIAS,
    parameter logic ROUND_EVEN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BCD_W-1:0]  dataIn,
    input  logic              R_I,
    output logic [HALF_W-1:0] dataOut,
    output logic              R_O,
    output logic              REG_ERROR
);

    // Exponent of a value whose leading one already sits in bit 13.
    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(ACC_W - 1 + EXP_BIAS);

    state_t              state_r,     state_s;
    logic [BCD_W-1:0]    operand_r,   operand_s;
    logic [ACC_W-1:0]    acc_r,       acc_s;
    logic [EXP_W-1:0]    exp_r,       exp_s;
    logic [1:0]          digit_cnt_r, digit_cnt_s;
    logic [HALF_W-1:0]   data_out_r,  data_out_s;
    logic                r_o_r,       r_o_s;
    logic                reg_error_r, reg_error_s;
    logic [HALF_W-1:0]   packed_s;

    half_pack_round #(
        .ROUND_EVEN (ROUND_EVEN)
    ) u_pack (
        .norm_val  (acc_r),
        .exp_val   (exp_r),
        .half_word (packed_s)
    );

    // Next-state and datapath update for the conversion sequence.
    always_comb begin
        state_s     = state_r;
        operand_s   = operand_r;
        acc_s       = acc_r;
        exp_s       = exp_r;
        digit_cnt_s = digit_cnt_r;
        data_out_s  = data_out_r;
        r_o_s       = 1'b0;
        reg_error_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (R_I) begin
                    operand_s = dataIn;
                    state_s   = CHECK;
                end else begin
                    state_s   = IDLE;
                end
            end
            CHECK: begin
                if (!bcd_valid(operand_r)) begin
                    reg_error_s = 1'b1;
                    state_s     = IDLE;
                end else begin
                    acc_s       = '0;
                    digit_cnt_s = 2'd0;
                    state_s     = ACC;
                end
            end
            ACC: begin
                // Digits are consumed from the top nibble, so shift the operand up.
                acc_s       = times_ten_plus(acc_r, operand_r[BCD_W-1 -: 4]);
                operand_s   = {operand_r[BCD_W-5:0], 4'h0};
                digit_cnt_s = digit_cnt_r + 2'd1;
                if (digit_cnt_r == 2'(DIGITS - 1)) begin
                    exp_s   = EXP_TOP;
                    state_s = NORM;
                end else begin
                    state_s = ACC;
                end
            end
            NORM: begin
                if ((acc_r == '0) || acc_r[ACC_W-1]) begin
                    state_s = ROUND;
                end else begin
                    acc_s   = {acc_r[ACC_W-2:0], 1'b0};
                    exp_s   = exp_r - 5'd1;
                    state_s = NORM;
                end
            end
            ROUND: begin
                data_out_s = packed_s;
                r_o_s      = 1'b1;
                state_s    = DONE;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            operand_r   <= '0;
            acc_r       <= '0;
            exp_r       <= '0;
            digit_cnt_r <= 2'd0;
            data_out_r  <= '0;
            r_o_r       <= 1'b0;
            reg_error_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            operand_r   <= operand_s;
            acc_r       <= acc_s;
            exp_r       <= exp_s;
            digit_cnt_r <= digit_cnt_s;
            data_out_r  <= data_out_s;
            r_o_r       <= r_o_s;
            reg_error_r <= reg_error_s;
        end
    end

    assign dataOut   = data_out_r;
    assign R_O       = r_o_r;
    assign REG_ERROR = reg_error_r;

endmodule

// File: tb/tb_bcd_to_half_fsm.sv
// Directed-vector bench for bcd_to_half_fsm: conversion results, latency,
// error pulses, retrigger immunity and asynchronous reset.
module tb_bcd_to_half_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dataIn;
    logic        R_I;
    logic [15:0] dataOut;
    logic        R_O;
    logic        REG_ERROR;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    bcd_to_half_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .dataIn    (dataIn),
        .R_I       (R_I),
        .dataOut   (dataOut),
        .R_O       (R_O),
        .REG_ERROR (REG_ERROR)
    );

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
        int          lat;
        logic        err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    // Runs ncyc edges after edge 0; R_I is high at edge 0 and over [ri_from, ri_to].
    task automatic run_window(input int ncyc, input int ri_from, input int ri_to,
                              input logic [15:0] din_a, input logic [15:0] din_b,
                              input int switch_at,
                              output int done_cnt, output int done_at,
                              output int err_cnt, output int err_at, output logic both);
        done_cnt = 0; done_at = -1; err_cnt = 0; err_at = -1; both = 1'b0;
        for (int n = 0; n <= ncyc; n++) begin
            @(negedge clk);
            R_I    = (n == 0) || (n >= ri_from && n <= ri_to);
            dataIn = (n >= switch_at) ? din_b : din_a;
            @(posedge clk);
            #1;
            if (R_O) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (REG_ERROR) begin
                err_cnt++;
                if (err_at < 0) err_at = n;
            end
            if (R_O && REG_ERROR) both = 1'b1;
        end
        @(negedge clk);
        R_I = 1'b0;
    endtask

    int   d_cnt, d_at, e_cnt, e_at;
    logic both_hi;

    initial begin
        vecs[0] = '{16'h0001, 16'h3C00, 20, 1'b0};
        vecs[1] = '{16'h1024, 16'h6400, 10, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000,  7, 1'b0};
        vecs[3] = '{16'h2049, 16'h6800,  9, 1'b0};
        vecs[4] = '{16'h2051, 16'h6802,  9, 1'b0};
        vecs[5] = '{16'h0003, 16'h4200, 19, 1'b0};
        vecs[6] = '{16'h9999, 16'h70E2,  7, 1'b0};
        vecs[7] = '{16'h12A4, 16'h70E2,  0, 1'b1};
        vecs[8] = '{16'hF999, 16'h70E2,  0, 1'b1};

        reset  = 1'b1;
        R_I    = 1'b0;
        dataIn = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dataOut", dataOut, 16'h0000);
        check("reset_R_O", R_O, 1'b0);
        check("reset_REG_ERROR", REG_ERROR, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_window(30, 0, 0, vecs[i].din, vecs[i].din, 0, d_cnt, d_at, e_cnt, e_at, both_hi);
            check($sformatf("v%0d_dataOut", i), dataOut, vecs[i].dout);
            check($sformatf("v%0d_both_high", i), both_hi, 1'b0);
            if (vecs[i].err) begin
                check($sformatf("v%0d_err_cnt", i), e_cnt, 1);
                check($sformatf("v%0d_err_at", i), e_at, 1);
                check($sformatf("v%0d_done_cnt", i), d_cnt, 0);
            end else begin
                check($sformatf("v%0d_done_cnt", i), d_cnt, 1);
                check($sformatf("v%0d_latency", i), d_at, vecs[i].lat);
                check($sformatf("v%0d_err_cnt", i), e_cnt, 0);
            end
        end

        // R_I held for three cycles at start: one conversion of 777.
        run_window(30, 0, 2, 16'h0777, 16'h0777, 0, d_cnt, d_at, e_cnt, e_at, both_hi);
        check("hold_done_cnt", d_cnt, 1);
        check("hold_latency", d_at, 11);
        check("hold_dataOut", dataOut, 16'h6212);

        // Retrigger during NORM and operand change mid-run are both ignored.
        run_window(40, 8, 12, 16'h0001, 16'h9999, 3, d_cnt, d_at, e_cnt, e_at, both_hi);
        check("retrig_done_cnt", d_cnt, 1);
        check("retrig_latency", d_at, 20);
        check("retrig_dataOut", dataOut, 16'h3C00);
        check("retrig_err_cnt", e_cnt, 0);

        // Asynchronous reset in the middle of ACC.
        @(negedge clk);
        dataIn = 16'h9999;
        R_I    = 1'b1;
        @(posedge clk);
        #1 R_I = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_rst_dataOut", dataOut, 16'h0000);
        check("async_rst_R_O", R_O, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_window(30, 0, 0, 16'h0005, 16'h0005, 0, d_cnt, d_at, e_cnt, e_at, both_hi);
        check("post_rst_done_cnt", d_cnt, 1);
        check("post_rst_latency", d_at, 18);
        check("post_rst_dataOut", dataOut, 16'h4500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
